ic_slv_arb: RTL and testbench
=============================

Name: ic_slv_arb

Overview:
- Per-slave address-channel arbiter, one instance per slave port of the fabric, directly downstream of the per-master address decoders.
- Takes each master's valid plus decoded slave index.
- Selects one master by round-robin and tracks outstanding transactions to this slave.
- Locks the slave to one master while that master has transactions in flight, so response routing needs no ID search.

Parameters:
MSTR_BITS, 2, master index width; MSTR_NUM = 2**MSTR_BITS masters
SLV_BITS, 3, decoded slave index width (matches decoder output)
SLV_ID, 0, slave index served by this instance
MAX_OUTS, 4, max outstanding transactions to this slave (1..2**CNT_BITS-1)
CNT_BITS, 3, outstanding counter width

Ports:
clk  in  1  fabric clock
reset  in  1  synchronous, active-low reset
M_AVALID  in  MSTR_NUM  address valid per master, bit m = master m
M_ASLV  in  MSTR_NUM*SLV_BITS  decoded slave index per master, slice [m*SLV_BITS +: SLV_BITS]
S_AREADY  in  1  slave address ready
S_RDONE  in  1  one-cycle pulse, last response of a transaction to this slave completed
GRANT  out  MSTR_NUM  one-hot grant, all-zero when idle
GRANT_IDX  out  MSTR_BITS  index of granted master; valid when GRANT != 0
S_AVALID  out  1  address valid forwarded to slave
OUTS_CNT  out  CNT_BITS  current outstanding count
OWNER_IDX  out  MSTR_BITS  master owning the slave while OUTS_CNT > 0
ERR  out  1  one-cycle pulse on S_RDONE with OUTS_CNT == 0

Behaviour:
- Clock and reset: single clock, all state on rising clk. Reset is synchronous and active-low.
- Reset values:
  - GRANT = 0, GRANT_IDX = 0, S_AVALID = 0, OUTS_CNT = 0, OWNER_IDX = 0, ERR = 0.
  - FSM = IDLE.
  - RR pointer LAST = MSTR_NUM-1, so master 0 has first priority.
- Request: req[m] = M_AVALID[m] & (M_ASLV slice m == SLV_ID).
- Eligibility, evaluated in IDLE:
  - OUTS_CNT == MAX_OUTS: no master eligible.
  - OUTS_CNT == 0: every requesting master eligible.
  - Otherwise: only OWNER_IDX eligible, if requesting.
- FSM has two states.
- IDLE:
  - If any eligible request: pick the first eligible index scanning LAST+1, LAST+2, … modulo MSTR_NUM.
  - Register GRANT, GRANT_IDX and LAST = pick; go to GRANTED.
  - Grant latency is 1 cycle after req asserts.
- GRANTED:
  - S_AVALID = req[GRANT_IDX], combinational from the registered grant.
  - Handshake (S_AVALID & S_AREADY): OUTS_CNT increments, OWNER_IDX = GRANT_IDX, GRANT cleared, go to IDLE.
  - req[GRANT_IDX] == 0 without handshake (illegal valid drop): GRANT cleared, go to IDLE, counter unchanged.
  - Otherwise hold the grant; a stalled slave holds the grant indefinitely.
- Throughput is at most one address every 2 cycles (grant cycle plus re-arbitration).
- Counter update:
  - Handshake only: +1.
  - S_RDONE only: -1.
  - Both in the same cycle: unchanged.
- Counter limits:
  - S_RDONE with OUTS_CNT == 0: counter stays 0, ERR pulses 1 cycle.
  - The counter never exceeds MAX_OUTS; the eligibility rule guarantees this.
- OWNER_IDX:
  - Retained while OUTS_CNT > 0.
  - When the count returns to 0, the next IDLE arbitration is open to all masters.
  - OWNER_IDX keeps its last value but is ignored.
- Reset mid-operation: on the first clk edge with reset low, all state returns to reset values, including an active grant and nonzero count.

Test Plan:
- Reset, then M_AVALID=4'b0001 with M_ASLV slice0 == SLV_ID, S_AREADY=1 -> GRANT=0001 one cycle later; S_AVALID=1 that cycle; OUTS_CNT=1 next cycle; back to IDLE.
- All 4 masters request continuously, S_RDONE pulsed after each handshake so OUTS_CNT returns to 0 between grants -> grants in order 0,1,2,3,0; no grant cycle ever shows GRANT with two bits set.
- Owner lock: master 1 handshakes (OUTS_CNT=1, no S_RDONE); masters 0 and 1 both request -> only master 1 granted. Master 0 is granted only in the IDLE cycle after S_RDONE returns OUTS_CNT to 0.
- Limit: MAX_OUTS=4, master 2 issues 4 addresses with no S_RDONE -> OUTS_CNT=4 and no fifth grant. One S_RDONE -> OUTS_CNT=3, and master 2 is granted again next cycle.
- Same-cycle handshake and S_RDONE with OUTS_CNT=2 -> OUTS_CNT stays 2. S_RDONE at OUTS_CNT=0 -> ERR=1 for exactly one cycle, counter stays 0.
- Master 3 granted with S_AREADY=0 and OUTS_CNT=2, then reset driven low for one clk -> next cycle GRANT=0, S_AVALID=0, OUTS_CNT=0. First grant after reset goes to master 0 when all masters request.

Source files
------------

// File: rtl/ic_slv_arb.sv
// Per-slave address-channel arbiter: round-robin over masters decoding to SLV_ID,
// with an outstanding-transaction counter that locks the slave to one owner.

module ic_slv_arb_lane #(
    parameter int SLV_BITS = 3,
    parameter int SLV_ID   = 0
) (
    input  logic                avalid,
    input  logic [SLV_BITS-1:0] aslv,
    output logic                req
);
    assign req = avalid && (aslv == SLV_BITS'(SLV_ID));
endmodule

module ic_slv_arb #(
    parameter int MSTR_BITS = 2,
    parameter int SLV_BITS  = 3,
    parameter int SLV_ID    = 0,
    parameter int MAX_OUTS  = 4,
    parameter int CNT_BITS  = 3,
    parameter int MSTR_NUM  = 2**MSTR_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MSTR_NUM-1:0]          M_AVALID,
    input  logic [MSTR_NUM*SLV_BITS-1:0] M_ASLV,
    input  logic                         S_AREADY,
    input  logic                         S_RDONE,
    output logic [MSTR_NUM-1:0]          GRANT,
    output logic [MSTR_BITS-1:0]         GRANT_IDX,
    output logic                         S_AVALID,
    output logic [CNT_BITS-1:0]          OUTS_CNT,
    output logic [MSTR_BITS-1:0]         OWNER_IDX,
    output logic                         ERR
);
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_GRANTED = 1'b1;

    logic                 state;
    logic [MSTR_BITS-1:0] last;
    logic [MSTR_NUM-1:0]  req;
    logic [MSTR_NUM-1:0]  elig;
    logic [MSTR_BITS-1:0] pick;
    logic [MSTR_BITS-1:0] cand;
    logic                 found;
    logic                 hs;

    genvar m;
    generate
        for (m = 0; m < MSTR_NUM; m++) begin : g_lane
            ic_slv_arb_lane #(.SLV_BITS(SLV_BITS), .SLV_ID(SLV_ID)) u_lane (
                .avalid (M_AVALID[m]),
                .aslv   (M_ASLV[m*SLV_BITS +: SLV_BITS]),
                .req    (req[m])
            );
        end
    endgenerate

    // A nonzero count pins the slave to its owner so responses route without ID lookup.
    always_comb begin
        elig = '0;
        if (OUTS_CNT == CNT_BITS'(MAX_OUTS))
            elig = '0;
        else if (OUTS_CNT == '0)
            elig = req;
        else
            elig = req & (MSTR_NUM'(1) << OWNER_IDX);
    end

    // Scan last+1 .. last+MSTR_NUM; index arithmetic wraps in MSTR_BITS.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= MSTR_NUM; i++) begin
            cand = last + MSTR_BITS'(i);
            if (!found && elig[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign S_AVALID = (state == ST_GRANTED) && req[GRANT_IDX];
    assign hs       = S_AVALID && S_AREADY;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            last      <= MSTR_BITS'(MSTR_NUM - 1);
            GRANT     <= '0;
            GRANT_IDX <= '0;
            OUTS_CNT  <= '0;
            OWNER_IDX <= '0;
            ERR       <= 1'b0;
        end else begin
            ERR <= S_RDONE && (OUTS_CNT == '0);

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        GRANT     <= MSTR_NUM'(1) << pick;
                        GRANT_IDX <= pick;
                        last      <= pick;
                        state     <= ST_GRANTED;
                    end
                end
                default: begin
                    if (hs) begin
                        GRANT     <= '0;
                        OWNER_IDX <= GRANT_IDX;
                        state     <= ST_IDLE;
                    end else if (!req[GRANT_IDX]) begin
                        GRANT <= '0;
                        state <= ST_IDLE;
                    end
                end
            endcase

            case ({hs, S_RDONE})
                2'b10:   OUTS_CNT <= OUTS_CNT + 1'b1;
                2'b01:   if (OUTS_CNT != '0) OUTS_CNT <= OUTS_CNT - 1'b1;
                default: OUTS_CNT <= OUTS_CNT;
            endcase
        end
    end
endmodule

// File: tb/tb_ic_slv_arb.sv
// Directed bench for ic_slv_arb: expected grants queued at stimulus time,
// popped by a negedge monitor on every new grant; counter/ERR checked directly.

module tb_ic_slv_arb;
    localparam int MSTR_BITS = 2;
    localparam int SLV_BITS  = 3;
    localparam int MSTR_NUM  = 4;
    localparam int CNT_BITS  = 3;

    logic                         clk = 1'b0;
    logic                         reset = 1'b0;
    logic [MSTR_NUM-1:0]          M_AVALID = '0;
    logic [MSTR_NUM*SLV_BITS-1:0] M_ASLV = '0;
    logic                         S_AREADY = 1'b0;
    logic                         S_RDONE = 1'b0;
    logic [MSTR_NUM-1:0]          GRANT;
    logic [MSTR_BITS-1:0]         GRANT_IDX;
    logic                         S_AVALID;
    logic [CNT_BITS-1:0]          OUTS_CNT;
    logic [MSTR_BITS-1:0]         OWNER_IDX;
    logic                         ERR;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    logic [MSTR_NUM-1:0] prev_g = '0;

    ic_slv_arb #(.MSTR_BITS(MSTR_BITS), .SLV_BITS(SLV_BITS), .SLV_ID(0),
                 .MAX_OUTS(4), .CNT_BITS(CNT_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .M_AVALID  (M_AVALID),
        .M_ASLV    (M_ASLV),
        .S_AREADY  (S_AREADY),
        .S_RDONE   (S_RDONE),
        .GRANT     (GRANT),
        .GRANT_IDX (GRANT_IDX),
        .S_AVALID  (S_AVALID),
        .OUTS_CNT  (OUTS_CNT),
        .OWNER_IDX (OWNER_IDX),
        .ERR       (ERR)
    );

    always #5 clk = ~clk;

    // Monitor: every fresh grant must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset && GRANT != '0 && prev_g == '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL grant_unexpected: got GRANT=%b idx=%0d, expected no grant", GRANT, GRANT_IDX);
            end else begin
                int e;
                logic [MSTR_NUM-1:0] oh;
                e  = exp_q.pop_front();
                oh = MSTR_NUM'(1) << e;
                if (GRANT !== oh || GRANT_IDX !== MSTR_BITS'(e)) begin
                    n_err++;
                    $display("FAIL grant_order: got GRANT=%b idx=%0d, expected GRANT=%b idx=%0d", GRANT, GRANT_IDX, oh, e);
                end
            end
        end
        prev_g = GRANT;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        M_AVALID = '0;
        M_ASLV   = '0;
        S_AREADY = 1'b0;
        S_RDONE  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One grant+handshake pass for master m, then release the slave with S_RDONE.
    task automatic rr_step(input int m);
        exp_q.push_back(m);
        tick();
        tick();
        M_AVALID[m] = 1'b0;
        S_RDONE     = 1'b1;
        tick();
        S_RDONE     = 1'b0;
        M_AVALID[m] = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_grant", int'(GRANT), 0);
        chk("reset_avalid", int'(S_AVALID), 0);
        chk("reset_cnt", int'(OUTS_CNT), 0);
        chk("reset_err", int'(ERR), 0);

        // Single transfer; master 2 targets another slave and must be ignored.
        M_ASLV   = {3'd0, 3'd5, 3'd0, 3'd0};
        M_AVALID = 4'b0101;
        S_AREADY = 1'b1;
        exp_q.push_back(0);
        tick();
        chk("t1_grant", int'(GRANT), 1);
        chk("t1_avalid", int'(S_AVALID), 1);
        tick();
        M_AVALID = 4'b0100;
        chk("t1_cnt", int'(OUTS_CNT), 1);
        chk("t1_grant_clr", int'(GRANT), 0);
        tick();
        tick();
        chk("t1_no_decode_grant", int'(GRANT), 0);

        // Round-robin order
        do_reset();
        S_AREADY = 1'b1;
        M_AVALID = 4'b1111;
        rr_step(0);
        rr_step(1);
        rr_step(2);
        rr_step(3);
        rr_step(0);
        M_AVALID = '0;
        tick();
        chk("rr_cnt", int'(OUTS_CNT), 0);

        // Owner lock
        do_reset();
        S_AREADY = 1'b1;
        M_AVALID = 4'b0010;
        exp_q.push_back(1);
        tick();
        tick();
        chk("lock_cnt1", int'(OUTS_CNT), 1);
        M_AVALID = 4'b0011;
        exp_q.push_back(1);
        tick();
        chk("lock_grant_m1", int'(GRANT), 2);
        tick();
        chk("lock_cnt2", int'(OUTS_CNT), 2);
        M_AVALID = 4'b0001;
        tick();
        chk("lock_m0_blocked", int'(GRANT), 0);
        S_RDONE = 1'b1;
        tick();
        chk("lock_m0_blocked2", int'(GRANT), 0);
        tick();
        S_RDONE = 1'b0;
        chk("lock_cnt0", int'(OUTS_CNT), 0);
        chk("lock_m0_wait", int'(GRANT), 0);
        exp_q.push_back(0);
        tick();
        chk("lock_m0_grant", int'(GRANT), 1);
        tick();
        M_AVALID = '0;

        // Outstanding limit
        do_reset();
        S_AREADY = 1'b1;
        M_AVALID = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2);
            tick();
            tick();
        end
        chk("lim_cnt4", int'(OUTS_CNT), 4);
        tick();
        tick();
        chk("lim_no_fifth", int'(GRANT), 0);
        chk("lim_cnt_hold", int'(OUTS_CNT), 4);
        S_RDONE = 1'b1;
        tick();
        S_RDONE = 1'b0;
        chk("lim_cnt3", int'(OUTS_CNT), 3);
        exp_q.push_back(2);
        tick();
        chk("lim_regrant", int'(GRANT), 4);
        tick();
        M_AVALID = '0;
        chk("lim_cnt_back4", int'(OUTS_CNT), 4);

        // Same-cycle handshake and S_RDONE, then ERR on underflow
        do_reset();
        S_AREADY = 1'b1;
        M_AVALID = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(2);
            tick();
            tick();
        end
        exp_q.push_back(2);
        tick();
        S_RDONE = 1'b1;
        tick();
        M_AVALID = '0;
        chk("both_cnt2", int'(OUTS_CNT), 2);
        tick();
        tick();
        chk("drain_cnt0", int'(OUTS_CNT), 0);
        chk("drain_no_err", int'(ERR), 0);
        tick();
        S_RDONE = 1'b0;
        chk("uf_err", int'(ERR), 1);
        chk("uf_cnt", int'(OUTS_CNT), 0);
        tick();
        chk("uf_err_pulse", int'(ERR), 0);

        // Stalled grant interrupted by reset
        do_reset();
        S_AREADY = 1'b1;
        M_AVALID = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(3);
            tick();
            tick();
        end
        S_AREADY = 1'b0;
        exp_q.push_back(3);
        tick();
        chk("stall_grant", int'(GRANT), 8);
        tick();
        chk("stall_hold", int'(GRANT), 8);
        chk("stall_cnt", int'(OUTS_CNT), 2);
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        M_AVALID = 4'b1111;
        S_AREADY = 1'b1;
        chk("rst_grant", int'(GRANT), 0);
        chk("rst_avalid", int'(S_AVALID), 0);
        chk("rst_cnt", int'(OUTS_CNT), 0);
        exp_q.push_back(0);
        tick();
        chk("rst_first_m0", int'(GRANT), 1);
        tick();
        M_AVALID = '0;
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
